// File: rtl/opqueue_sequencer_pkg.sv
// Shared types and helpers for the lane operand-queue issue sequencer.
// Contents:
//   VlWidth / WordsWidth  vector-length width and word-counter width
//   opq_cmd_t             command pushed into the operand queue {vl, eew, conv}
//   opq_seq_state_e       sequencer FSM states
//   opq_words()           VRF words needed for vl elements of a given EEW
package opqueue_sequencer_pkg;

    localparam int VlWidth    = 16;
    localparam int WordsWidth = VlWidth + 4;

    typedef struct packed {
        logic [VlWidth-1:0] vl;
        logic [1:0]         eew;
        logic [3:0]         conv;
    } opq_cmd_t;

    typedef enum logic {
        IDLE,
        ISSUE
    } opq_seq_state_e;

    // Bytes = vl << eew, rounded up to whole 64-bit words. The four extra bits
    // hold vl*8+7 without overflow, so the full vl range is safe.
    function automatic logic [WordsWidth-1:0] opq_words(input logic [VlWidth-1:0] vl,
                                                        input logic [1:0]         eew);
        logic [WordsWidth-1:0] bytes;
        bytes = {4'b0000, vl} << eew;
        return (bytes + WordsWidth'(7)) >> 3;
    endfunction

endpackage

// File: rtl/opqueue_sequencer_if.sv
// Handshake bundle between requesters, the operand queue, the VRF and the
// sequencer.
//   master : sequencer side (accepts requests, pushes commands, issues reads)
//   slave  : environment side (requesters, operand queue, VRF)
// Request fields are packed per requester: index i occupies slice
// [i*W +: W] of the corresponding vector.
interface opqueue_sequencer_if #(
    parameter int NrRequesters = 2,
    parameter int AddrWidth    = 10
);
    import opqueue_sequencer_pkg::*;

    logic [NrRequesters-1:0]           req_valid_i;
    logic [NrRequesters-1:0]           req_ready_o;
    logic [NrRequesters*VlWidth-1:0]   req_vl_i;
    logic [NrRequesters*2-1:0]         req_eew_i;
    logic [NrRequesters*4-1:0]         req_conv_i;
    logic [NrRequesters*AddrWidth-1:0] req_addr_i;

    opq_cmd_t                          opq_cmd_o;
    logic                              opq_cmd_valid_o;
    logic                              opq_cmd_pop_i;
    logic                              opq_ready_i;

    logic                              vrf_req_o;
    logic [AddrWidth-1:0]              vrf_addr_o;
    logic                              vrf_gnt_i;

    modport master (
        input  req_valid_i, req_vl_i, req_eew_i, req_conv_i, req_addr_i,
        input  opq_cmd_pop_i, opq_ready_i, vrf_gnt_i,
        output req_ready_o, opq_cmd_o, opq_cmd_valid_o, vrf_req_o, vrf_addr_o
    );

    modport slave (
        output req_valid_i, req_vl_i, req_eew_i, req_conv_i, req_addr_i,
        output opq_cmd_pop_i, opq_ready_i, vrf_gnt_i,
        input  req_ready_o, opq_cmd_o, opq_cmd_valid_o, vrf_req_o, vrf_addr_o
    );

endinterface

// File: rtl/opqueue_seq_rr_arbiter.sv
// Round-robin picker for the operand sequencer.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   valid_i        per-requester request valid
//   en_i           arbitration allowed this cycle
//   gnt_o          one-hot grant (all zero when en_i is low or nothing valid)
//   any_o          a grant was issued
// The pointer moves to winner+1 only when a grant is actually issued.
module opqueue_seq_rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [N-1:0] valid_i,
    input  logic         en_i,
    output logic [N-1:0] gnt_o,
    output logic         any_o
);
    localparam int PtrW = (N > 1) ? $clog2(N) : 1;

    logic [PtrW-1:0] ptr_q, ptr_d;
    logic [PtrW-1:0] win;
    logic [PtrW-1:0] idx;
    logic            found;

    always_comb begin
        win   = '0;
        idx   = '0;
        found = 1'b0;
        for (int off = 0; off < N; off++) begin
            idx = PtrW'((int'(ptr_q) + off) % N);
            if (!found && valid_i[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        any_o = en_i & found;
        gnt_o = '0;
        for (int i = 0; i < N; i++) begin
            gnt_o[i] = any_o && (win == PtrW'(i));
        end
        ptr_d = ptr_q;
        if (any_o) begin
            ptr_d = (int'(win) == N - 1) ? '0 : win + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/opqueue_sequencer.sv
// Issue-side controller for one lane operand queue.
// Arbitrates operand-read requests round-robin, pushes the winner's
// conversion command into the operand queue, then issues one VRF word read
// per cycle, gated by queue credit (opq_ready_i) and VRF grant.
// Command-buffer occupancy is tracked so the queue never overflows.
// Ports:
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   bus (master)      requests, queue command/credit, VRF read handshake
//   operand_issued_o  a VRF read completed this cycle (queue credit consumed)
//   busy_o            a stream is being issued
// Configuration:
//   OPQ_SEQ_BACK2BACK_EN  when defined, arbitration also runs in the cycle the
//                         final word is granted, removing the idle bubble
//                         between streams.
// State table:
//   IDLE  | waiting for an eligible request
//   ISSUE | reading the latched stream from the VRF, one word per grant
module opqueue_sequencer
    import opqueue_sequencer_pkg::*;
#(
    parameter int NrRequesters = 2,
    parameter int CmdBufDepth  = 2,
    parameter int AddrWidth    = 10
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    opqueue_sequencer_if.master bus,
    output logic                operand_issued_o,
    output logic                busy_o
);
    localparam int CredW = $clog2(CmdBufDepth + 1);

    opq_seq_state_e          state_q, state_d;
    logic [WordsWidth-1:0]   words_q, words_d;
    logic [AddrWidth-1:0]    addr_q, addr_d;
    logic [CredW-1:0]        credits_q, credits_d;

    logic [NrRequesters-1:0] gnt;
    logic                    arb_en, accept, push, fire, last_word, credit_ok, in_issue;
    logic [VlWidth-1:0]      sel_vl;
    logic [1:0]              sel_eew;
    logic [3:0]              sel_conv;
    logic [AddrWidth-1:0]    sel_addr;

    assign in_issue  = (state_q == ISSUE);
    assign credit_ok = credits_q < CredW'(CmdBufDepth);
    assign fire      = bus.vrf_req_o & bus.vrf_gnt_i;
    assign last_word = fire & (words_q == WordsWidth'(1));

    // rst_ni gates arbitration so no accept is signalled while held in reset.
`ifdef OPQ_SEQ_BACK2BACK_EN
    assign arb_en = rst_ni & credit_ok & (~in_issue | last_word);
`else
    assign arb_en = rst_ni & credit_ok & ~in_issue;
`endif

    opqueue_seq_rr_arbiter #(.N(NrRequesters)) u_arb (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (bus.req_valid_i),
        .en_i    (arb_en),
        .gnt_o   (gnt),
        .any_o   (accept)
    );

    always_comb begin
        sel_vl   = '0;
        sel_eew  = '0;
        sel_conv = '0;
        sel_addr = '0;
        for (int i = 0; i < NrRequesters; i++) begin
            if (gnt[i]) begin
                sel_vl   = bus.req_vl_i[i*VlWidth +: VlWidth];
                sel_eew  = bus.req_eew_i[i*2 +: 2];
                sel_conv = bus.req_conv_i[i*4 +: 4];
                sel_addr = bus.req_addr_i[i*AddrWidth +: AddrWidth];
            end
        end
    end

    // A zero-length request is accepted and dropped: no push, no credit.
    assign push = accept & (sel_vl != '0);

    assign bus.req_ready_o     = gnt;
    assign bus.opq_cmd_valid_o = push;
    assign bus.opq_cmd_o       = push ? '{vl: sel_vl, eew: sel_eew, conv: sel_conv} : '0;
    assign bus.vrf_req_o       = in_issue & bus.opq_ready_i;
    assign bus.vrf_addr_o      = addr_q;
    assign operand_issued_o    = fire;
    assign busy_o              = in_issue;

    always_comb begin
        state_d = state_q;
        words_d = words_q;
        addr_d  = addr_q;
        if (fire) begin
            words_d = words_q - 1'b1;
            addr_d  = addr_q + 1'b1;
        end
        if (last_word) begin
            state_d = IDLE;
        end
        // A new accept overrides the completion of the previous stream.
        if (push) begin
            state_d = ISSUE;
            words_d = opq_words(sel_vl, sel_eew);
            addr_d  = sel_addr;
        end

        credits_d = credits_q;
        case ({push, bus.opq_cmd_pop_i})
            2'b10:   credits_d = credits_q + 1'b1;
            2'b01:   if (credits_q != '0) credits_d = credits_q - 1'b1;
            default: credits_d = credits_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            words_q   <= '0;
            addr_q    <= '0;
            credits_q <= '0;
        end else begin
            state_q   <= state_d;
            words_q   <= words_d;
            addr_q    <= addr_d;
            credits_q <= credits_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            assert ($onehot0(bus.req_ready_o));
            assert (!(bus.vrf_req_o && !bus.opq_ready_i));
            assert (!(bus.opq_cmd_valid_o && credits_q == CredW'(CmdBufDepth)));
            assert (!(bus.opq_cmd_pop_i && credits_q == '0));
        end
    end

endmodule

// File: doc/opqueue_sequencer.md
Name: opqueue_sequencer

Overview:
- Issue-side controller for one lane operand queue.
- Round-robin arbitrates operand-read requests from several requesters (e.g. instruction issue slots).
- For the winning request: pushes the conversion command into the queue, then issues one VRF word read per cycle. Reads are gated by the queue's credit-based ready and the VRF grant.
- Also guarantees the queue's command buffer never overflows.

Parameters:
- NrRequesters, 2, number of requesting sources (≥1).
- CmdBufDepth, 2, depth of the operand queue command buffer; bounds outstanding commands.
- VlWidth, 16, width of the vector-length field in elements.
- AddrWidth, 10, VRF word-address width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  NrRequesters  per-requester request valid
- req_ready_o  out  NrRequesters  one-hot accept; at most one bit high per cycle
- req_vl_i  in  NrRequesters*VlWidth  element count
- req_eew_i  in  NrRequesters*2  source EEW (0=EW8..3=EW64)
- req_conv_i  in  NrRequesters*4  operand-queue conversion code
- req_addr_i  in  NrRequesters*AddrWidth  first VRF word address
- opq_cmd_o  out  opq_cmd_t  {vl, eew, conv} pushed to queue
- opq_cmd_valid_o  out  1  single-cycle push strobe
- opq_cmd_pop_i  in  1  queue retired a command
- opq_ready_i  in  1  queue credit available
- vrf_req_o  out  1  VRF read request
- vrf_addr_o  out  AddrWidth  read address
- vrf_gnt_i  in  1  VRF grant
- operand_issued_o  out  1  = vrf_req_o & vrf_gnt_i (queue credit consume)
- busy_o  out  1  state != IDLE

Behaviour:
- Reset: all outputs 0; state IDLE; RR pointer 0; cmd credit count 0; word counter and address 0.
- Word count per request: words = ((vl << eew) + 7) >> 3. Compute in VlWidth+4 bits, with no overflow. The conversion code never changes the read count.
- IDLE:
  - Eligible when cmd credits < CmdBufDepth.
  - Pick the first valid requester at or after the RR pointer.
  - Same cycle: req_ready_o[winner]=1, opq_cmd_valid_o=1, latch addr/words; then RR pointer = winner+1 (mod NrRequesters).
  - Next state is ISSUE.
  - vl==0: accept and drop. No cmd push, no credit taken, stay IDLE, RR pointer still advances.
  - No valid requester, or credits full: all ready low, no push.
- ISSUE:
  - vrf_req_o = opq_ready_i; vrf_addr_o = latched address.
  - A read completes only when vrf_req_o & vrf_gnt_i. Then words -= 1 and address += 1, wrapping modulo 2^AddrWidth.
  - Grant without request is ignored.
  - When the final word is granted, go to IDLE. One-cycle bubble before the next accept, unless the optional feature is enabled.
- Request handshake: once req_valid_i is high, requester fields are stable until the same-index req_ready_o.
- Cmd credits:
  - +1 on opq_cmd_valid_o, −1 on opq_cmd_pop_i; push and pop in the same cycle leave it unchanged.
  - Pop at count 0 is an assertion error; the count saturates at 0.
- Latency: accept to first possible vrf_req_o is 1 cycle.
- Throughput: 1 word/cycle while opq_ready_i and vrf_gnt_i are held high.
- Reset mid-ISSUE: abort immediately to the reset state. The queue is reset alongside, so no credit reconciliation is needed.
- Assertions:
  - req_ready_o is one-hot0.
  - vrf_req_o is never high while opq_ready_i is low.
  - opq_cmd_valid_o is never high while credits == CmdBufDepth.

Optional Feature:
- Macro: OPQ_SEQ_BACK2BACK_EN.
- Defined: in the cycle the final word is granted, the IDLE arbitration also runs. If a request is accepted, the next state is ISSUE with the new context, giving gapless streams. Credit check uses the count as registered this cycle.
- Undefined: the one-cycle IDLE bubble above applies.

Decomposition:
- ara_pkg gains:
  - opq_cmd_t (vl, eew, conv).
  - opq_seq_state_e {IDLE, ISSUE}.
  - Function opq_words(vl, eew) implementing the word-count formula, shared with the operand requester.
- One sub-module, opqueue_seq_rr_arbiter: combinational pick plus registered pointer, advanced only on accept.

Test Plan:
- Single request vl=17, eew=EW16, addr=0x10, opq_ready/gnt tied 1:
  - Expect 1 cmd push, then 5 reads at 0x10..0x14 on consecutive cycles.
  - operand_issued_o pulses 5 times; busy_o drops after the last read.
- Two requesters held valid continuously:
  - Accepts alternate 0,1,0,1.
  - With NrRequesters=3 and only 0 and 2 valid, order is 0,2,0.
- opq_ready_i toggled 1,0,0,1 during a 4-word stream:
  - vrf_req_o follows it; address advances only on granted cycles.
  - vrf_gnt_i low for 2 cycles stalls with address held.
- Three back-to-back requests with CmdBufDepth=2 and no opq_cmd_pop_i:
  - Third is not accepted until a pop. Pop and push in the same cycle keep the count at 2.
- Edge cases:
  - vl=0 is accepted in 1 cycle with no push and no reads.
  - vl=1 eew=EW8 → 1 word.
  - vl=8 eew=EW64 → 8 words.
  - addr=2^AddrWidth−1 with 2 words wraps to 0.
- Reset asserted mid-stream after 2 of 6 words: all outputs 0 asynchronously, busy_o=0.
  - After release, a new request starts cleanly.
  - With OPQ_SEQ_BACK2BACK_EN, the next request's first read immediately follows the prior last grant.
